// File: rtl/block_code_a20_encoder.sv
// (20,A) block-code encoder: streams the 20 coded bits of one info word per codeword.
// Optional BPSK soft-symbol output is compiled in with `define BLOCK_CODE_SOFT_OUT_EN.
module block_code_a20_encoder #(
  parameter int DATA_WIDTH = 4,
  parameter int CODE_N     = 20,
  parameter int MAX_A      = 13
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAX_A-1:0]             info_bits,
  input  logic [3:0]                   info_length,
  input  logic                         info_valid,
  output logic                         info_ready,
  output logic                         tx_bit,
`ifdef BLOCK_CODE_SOFT_OUT_EN
  output logic signed [DATA_WIDTH-1:0] tx_symbol,
`endif
  output logic [4:0]                   tx_index,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         tx_last
);

  if (CODE_N != 20) begin : g_bad_code_n
    $error("block_code_a20_encoder: CODE_N must be 20");
  end
  if (MAX_A != 13) begin : g_bad_max_a
    $error("block_code_a20_encoder: MAX_A must be 13");
  end
  if (DATA_WIDTH < 2) begin : g_bad_data_width
    $error("block_code_a20_encoder: DATA_WIDTH must be at least 2");
  end

  localparam logic [4:0] LAST_IDX = 5'(CODE_N - 1);

`ifdef BLOCK_CODE_SOFT_OUT_EN
  localparam logic signed [DATA_WIDTH-1:0] SOFT_POS = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] SOFT_NEG = -SOFT_POS;
`endif

  // Basis rows: bit n of row i is M(i,n).
  function automatic logic [12:0] basis_row(input logic [4:0] i);
    case (i)
      5'd0:    basis_row = 13'b0110000000011;
      5'd1:    basis_row = 13'b0111000000111;
      5'd2:    basis_row = 13'b1111101001001;
      5'd3:    basis_row = 13'b1110100001101;
      5'd4:    basis_row = 13'b1110010001111;
      5'd5:    basis_row = 13'b1110111010011;
      5'd6:    basis_row = 13'b1111101010101;
      5'd7:    basis_row = 13'b1110110011001;
      5'd8:    basis_row = 13'b1111010011011;
      5'd9:    basis_row = 13'b1111001011101;
      5'd10:   basis_row = 13'b1111011100101;
      5'd11:   basis_row = 13'b1110101100111;
      5'd12:   basis_row = 13'b1111110101001;
      5'd13:   basis_row = 13'b1111010101011;
      5'd14:   basis_row = 13'b1010010110001;
      5'd15:   basis_row = 13'b1011011110011;
      5'd16:   basis_row = 13'b1101001110111;
      5'd17:   basis_row = 13'b1100100111001;
      5'd18:   basis_row = 13'b0000011111011;
      5'd19:   basis_row = 13'b0000001100001;
      default: basis_row = 13'b0;
    endcase
  endfunction

  function automatic logic coded_bit(input logic [12:0] info, input logic [4:0] i);
    coded_bit = ^(info & basis_row(i));
  endfunction

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic [MAX_A-1:0]   info_q, info_d;
  logic               bit_q, bit_d;
  logic [MAX_A-1:0]   len_mask;
  logic [MAX_A-1:0]   masked_info;
  logic               accept;
  logic               beat_done;

  // Lengths above MAX_A naturally saturate to all-ones here.
  always_comb begin
    len_mask = '0;
    for (int n = 0; n < MAX_A; n++) begin
      if (n < int'(info_length)) len_mask[n] = 1'b1;
    end
  end

  assign masked_info = info_bits & len_mask;

  assign tx_valid   = (state_q == SEND);
  assign tx_index   = idx_q;
  assign tx_bit     = bit_q;
  assign tx_last    = (state_q == SEND) && (idx_q == LAST_IDX);
  assign info_ready = !rst && ((state_q == IDLE) || (tx_ready && tx_last));
  assign accept     = info_valid && info_ready;
  assign beat_done  = tx_valid && tx_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    info_d  = info_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          info_d  = masked_info;
          idx_d   = 5'd0;
          bit_d   = coded_bit(masked_info, 5'd0);
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 5'd1;
            bit_d = coded_bit(info_q, idx_q + 5'd1);
          end else if (accept) begin
            info_d = masked_info;
            idx_d  = 5'd0;
            bit_d  = coded_bit(masked_info, 5'd0);
          end else begin
            idx_d   = 5'd0;
            bit_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BLOCK_CODE_SOFT_OUT_EN
  logic signed [DATA_WIDTH-1:0] sym_q, sym_d;

  always_comb begin
    sym_d = '0;
    if (state_d == SEND) sym_d = bit_d ? SOFT_NEG : SOFT_POS;
  end

  always_ff @(posedge clk) begin
    if (rst) sym_q <= '0;
    else     sym_q <= sym_d;
  end

  assign tx_symbol = sym_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      info_q  <= '0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      info_q  <= info_d;
      bit_q   <= bit_d;
    end
  end

endmodule
